traffic_light_ctrl: RTL and testbench



---
 rtl/traffic_light_ctrl.sv | 163 ++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light sequencer with a latched pedestrian request.
// The sticky timer TICK supplies the phase time base. After each tick event,
// TMR_RES pulses for one cycle to re-arm the timer.
//
// state     | meaning
// ----------+----------------------------------------------
// RED_TO_NS | all-red clearance before north-south green
// NS_GREEN  | north-south green, east-west red
// NS_YELLOW | north-south yellow, east-west red
// RED_TO_EW | all-red clearance before east-west green
// EW_GREEN  | east-west green, north-south red
// EW_YELLOW | east-west yellow, north-south red
// PED_WALK  | both roads red, walk lamp on
`timescale 1ns/1ps
module traffic_light_ctrl #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int RED_TICKS    = 1,
    parameter int WALK_TICKS   = 4
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       TICK,
    input  logic       PED_REQ,
    output logic       TMR_RES,
    output logic       NS_R,
    output logic       NS_Y,
    output logic       NS_G,
    output logic       EW_R,
    output logic       EW_Y,
    output logic       EW_G,
    output logic       WALK,
    output logic       PED_PEND,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        RED_TO_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        RED_TO_EW = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] phase_cnt, phase_cnt_d;
    logic [7:0] dur;
    logic       tick_d;
    logic       tick_ev;
    logic       ped_sync1, ped_sync2;
    logic       ped_clr;
    logic       ns_r_d, ns_y_d, ns_g_d, ew_r_d, ew_y_d, ew_g_d, walk_d;

    assign tick_ev = TICK & ~tick_d;
    assign STATE   = state_q;

    // Edge detect on the sticky tick, and the one-cycle timer re-arm pulse.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            tick_d  <= 1'b0;
            TMR_RES <= 1'b1;
        end else begin
            tick_d  <= TICK;
            TMR_RES <= tick_ev;
        end
    end

    // Two-flop synchronizer for the pedestrian button and the pending latch.
    // A coincident set beats the clear so no request is lost on walk entry.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            ped_sync1 <= 1'b0;
            ped_sync2 <= 1'b0;
            PED_PEND  <= 1'b0;
        end else begin
            ped_sync1 <= PED_REQ;
            ped_sync2 <= ped_sync1;
            PED_PEND  <= ped_sync2 | (PED_PEND & ~ped_clr);
        end
    end

    // Next-state, phase counter and lamp decode of the next state.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt;
        dur         = 8'(RED_TICKS);
        ped_clr     = 1'b0;

        case (state_q)
            RED_TO_NS, RED_TO_EW: dur = 8'(RED_TICKS);
            NS_GREEN, EW_GREEN:   dur = 8'(GREEN_TICKS);
            NS_YELLOW, EW_YELLOW: dur = 8'(YELLOW_TICKS);
            PED_WALK:             dur = 8'(WALK_TICKS);
            default:              dur = 8'(RED_TICKS);
        endcase

        case (state_q)
            RED_TO_NS, NS_GREEN, NS_YELLOW, RED_TO_EW,
            EW_GREEN, EW_YELLOW, PED_WALK: begin
                if (tick_ev) begin
                    if (phase_cnt == dur - 8'd1) begin
                        phase_cnt_d = 8'd0;
                        case (state_q)
                            RED_TO_NS: state_d = NS_GREEN;
                            NS_GREEN:  state_d = NS_YELLOW;
                            NS_YELLOW: state_d = RED_TO_EW;
                            RED_TO_EW: state_d = EW_GREEN;
                            EW_GREEN:  state_d = EW_YELLOW;
                            EW_YELLOW: state_d = PED_PEND ? PED_WALK : RED_TO_NS;
                            default:   state_d = RED_TO_NS;
                        endcase
                    end else begin
                        phase_cnt_d = phase_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_d     = RED_TO_NS;
                phase_cnt_d = 8'd0;
            end
        endcase

        if (state_d == PED_WALK && state_q != PED_WALK) begin
            ped_clr = 1'b1;
        end

        ns_g_d = (state_d == NS_GREEN);
        ns_y_d = (state_d == NS_YELLOW);
        ns_r_d = ~(ns_g_d | ns_y_d);
        ew_g_d = (state_d == EW_GREEN);
        ew_y_d = (state_d == EW_YELLOW);
        ew_r_d = ~(ew_g_d | ew_y_d);
        walk_d = (state_d == PED_WALK);
    end

    // State, phase counter and lamp registers update together.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q   <= RED_TO_NS;
            phase_cnt <= 8'd0;
            NS_R      <= 1'b1;
            NS_Y      <= 1'b0;
            NS_G      <= 1'b0;
            EW_R      <= 1'b1;
            EW_Y      <= 1'b0;
            EW_G      <= 1'b0;
            WALK      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_cnt <= phase_cnt_d;
            NS_R      <= ns_r_d;
            NS_Y      <= ns_y_d;
            NS_G      <= ns_g_d;
            EW_R      <= ew_r_d;
            EW_Y      <= ew_y_d;
            EW_G      <= ew_g_d;
            WALK      <= walk_d;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with short phase durations.
`timescale 1ns/1ps
module tb_traffic_light_ctrl;

    logic       CLK = 1'b0;
    logic       RES;
    logic       TICK;
    logic       PED_REQ;
    logic       TMR_RES;
    logic       NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G;
    logic       WALK;
    logic       PED_PEND;
    logic [2:0] STATE;

    int vectors = 0;
    int errors  = 0;
    int pulses;

    traffic_light_ctrl #(
        .GREEN_TICKS (3),
        .YELLOW_TICKS(1),
        .RED_TICKS   (1),
        .WALK_TICKS  (2)
    ) dut (
        .CLK     (CLK),
        .RES     (RES),
        .TICK    (TICK),
        .PED_REQ (PED_REQ),
        .TMR_RES (TMR_RES),
        .NS_R    (NS_R),
        .NS_Y    (NS_Y),
        .NS_G    (NS_G),
        .EW_R    (EW_R),
        .EW_Y    (EW_Y),
        .EW_G    (EW_G),
        .WALK    (WALK),
        .PED_PEND(PED_PEND),
        .STATE   (STATE)
    );

    // 10 ns system clock.
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle tick, then check the state reached and the TMR_RES pulse shape.
    task automatic tick_pulse(input string tag, input logic [2:0] exp_state);
        @(negedge CLK) TICK = 1'b1;
        @(posedge CLK) #1;
        chk({tag, "_state"}, 8'(STATE), 8'(exp_state));
        chk({tag, "_tmr_hi"}, 8'(TMR_RES), 8'd1);
        @(negedge CLK) TICK = 1'b0;
        @(posedge CLK) #1;
        chk({tag, "_tmr_lo"}, 8'(TMR_RES), 8'd0);
    endtask

    initial begin
        RES = 1'b0; TICK = 1'b0; PED_REQ = 1'b0;

        // Reset values, sampled mid-cycle while reset is held.
        #13;
        chk("rst_state", 8'(STATE), 8'd0);
        chk("rst_lamps", {1'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK}, 8'b0100_1000);
        chk("rst_tmr",   8'(TMR_RES), 8'd1);
        chk("rst_pend",  8'(PED_PEND), 8'd0);
        @(negedge CLK) RES = 1'b1;
        @(posedge CLK) #1;
        chk("rel_tmr", 8'(TMR_RES), 8'd0);

        // Full cycle without pedestrian.
        tick_pulse("c1", 3'd1);
        chk("ns_green_lamps", {1'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK}, 8'b0001_1000);
        tick_pulse("c2", 3'd1);
        tick_pulse("c3", 3'd1);
        tick_pulse("c4", 3'd2);
        chk("ns_yellow_lamps", {1'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK}, 8'b0010_1000);
        tick_pulse("c5", 3'd3);
        chk("red_to_ew_lamps", {1'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK}, 8'b0100_1000);
        tick_pulse("c6", 3'd4);
        chk("ew_green_lamps", {1'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK}, 8'b0100_0010);
        tick_pulse("c7", 3'd4);
        tick_pulse("c8", 3'd4);
        tick_pulse("c9", 3'd5);
        chk("ew_yellow_lamps", {1'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK}, 8'b0100_0100);
        tick_pulse("c10", 3'd0);

        // Pedestrian request during NS_GREEN, served after EW_YELLOW.
        tick_pulse("p1", 3'd1);
        @(negedge CLK) PED_REQ = 1'b1;
        @(negedge CLK) PED_REQ = 1'b0;
        @(posedge CLK) #1;
        chk("pend_edge2", 8'(PED_PEND), 8'd0);
        @(posedge CLK) #1;
        chk("pend_edge3", 8'(PED_PEND), 8'd1);
        tick_pulse("p2", 3'd1);
        tick_pulse("p3", 3'd1);
        tick_pulse("p4", 3'd2);
        tick_pulse("p5", 3'd3);
        tick_pulse("p6", 3'd4);
        tick_pulse("p7", 3'd4);
        tick_pulse("p8", 3'd4);
        tick_pulse("p9", 3'd5);
        tick_pulse("p10", 3'd6);
        chk("walk_lamps", {1'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK}, 8'b0100_1001);
        chk("walk_pend", 8'(PED_PEND), 8'd0);
        tick_pulse("p11", 3'd6);
        tick_pulse("p12", 3'd0);
        chk("post_walk", 8'(WALK), 8'd0);

        // Held tick: one event only.
        tick_pulse("h1", 3'd1);
        pulses = 0;
        @(negedge CLK) TICK = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK) #1;
            if (TMR_RES) pulses++;
        end
        chk("held_pulses", 8'(pulses), 8'd1);
        chk("held_state", 8'(STATE), 8'd1);
        @(negedge CLK) TICK = 1'b0;
        @(posedge CLK) #1;
        tick_pulse("h2", 3'd1);
        tick_pulse("h3", 3'd2);

        // Asynchronous reset mid EW_GREEN with a pending request.
        tick_pulse("r1", 3'd3);
        tick_pulse("r2", 3'd4);
        @(negedge CLK) PED_REQ = 1'b1;
        @(negedge CLK) PED_REQ = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("ar_pend_set", 8'(PED_PEND), 8'd1);
        @(negedge CLK) #2 RES = 1'b0;
        #1;
        chk("ar_state", 8'(STATE), 8'd0);
        chk("ar_lamps", {1'b0, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, WALK}, 8'b0100_1000);
        chk("ar_tmr",  8'(TMR_RES), 8'd1);
        chk("ar_pend", 8'(PED_PEND), 8'd0);
        @(negedge CLK) RES = 1'b1;
        @(posedge CLK) #1;
        chk("ar_rel_tmr", 8'(TMR_RES), 8'd0);
        tick_pulse("ar_t1", 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
